// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a small transmit FIFO.
//
// The host pushes words with tx_start. Queued words are sent as frames made of
// a start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. When a frame ends and the FIFO holds another word, the
// next start bit follows with no idle cycle in between.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-high
//   tx_start  push data_in into the FIFO on this edge (dropped if full)
//   data_in   word to send, sampled only on the push edge
//   tx_ready  registered; FIFO not full, so a tx_start now is accepted
//   overflow  registered 1-cycle pulse: a push arrived while the FIFO was full
//   tx        registered serial output, idles high
//   busy      registered; a frame is in progress or words are queued
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_ready,
  output logic                 overflow,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~(^d);
    end
    return ^d;
  endfunction

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Serialiser state
  state_t               state;
  state_t               state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_next;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_next;
  logic                 tx_next;
  logic                 shift_en;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 baud_done;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push      = tx_start & ~full;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Next-state logic. tx_next is the value tx takes after this edge, so each
  // branch that enters a new bit also chooses that bit's line level.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    tx_next    = tx;
    pop        = 1'b0;
    shift_en   = 1'b0;
    case (state)
      S_IDLE: begin
        tx_next   = 1'b1;
        baud_next = '0;
        bit_next  = '0;
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
          tx_next    = shift_q[0];
          shift_en   = 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              tx_next    = par_q;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + 4'd1;
            tx_next  = shift_q[0];
            shift_en = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_STOP;
          tx_next    = 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_next = '0;
            // Back-to-back frames: pop and start the next frame on this edge.
            if (!empty) begin
              pop        = 1'b1;
              state_next = S_START;
              tx_next    = 1'b0;
            end else begin
              state_next = S_IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + 4'd1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Control registers: reset asynchronously so tx returns high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
      overflow <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      tx       <= tx_next;
      busy     <= (state_next != S_IDLE) || (count_next != '0);
      tx_ready <= (count_next != CNT_FULL);
      overflow <= tx_start & full;
      count    <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Data registers: contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data_in;
    end
    if (pop) begin
      shift_q <= fifo_mem[rd_ptr];
      par_q   <= parity_bit(fifo_mem[rd_ptr]);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule
